// File: rtl/axi4l_slave_mem.sv
// rtl/axi4l_slave_mem.sv - AXI4-Lite responder backed by a word-organised on-chip memory
// Independent write/read engines, one outstanding transaction each, byte-strobe writes.
module axi4l_slave_mem #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic                    WVALID,
    output logic                    WREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic [1:0]              BRESP,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP
);
    localparam int                    STRB_W    = DATA_WIDTH / 8;
    localparam int                    IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(DEPTH_WORDS * 4);

    typedef enum logic {W_ACCEPT, W_RESP} w_state_t;
    typedef enum logic {R_ACCEPT, R_DATA} r_state_t;

    // Borrow out of the subtraction flags addresses below BASE_ADDR.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH:0] diff;
        diff = {1'b0, addr} - {1'b0, BASE_ADDR};
        return !diff[ADDR_WIDTH] && (diff[ADDR_WIDTH-1:0] < MEM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    w_state_t              w_state_q, w_state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;

    r_state_t              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    // Commit uses the bypassed AW/W values so a same-cycle handshake writes on that edge.
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        wr_addr   = awaddr_q;
        wr_data   = wdata_q;
        wr_strb   = wstrb_q;
        case (w_state_q)
            W_ACCEPT: begin
                if (AWVALID && awready_q) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = AWADDR;
                    wr_addr   = AWADDR;
                end
                if (WVALID && wready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = WDATA;
                    wstrb_d  = WSTRB;
                    wr_data  = WDATA;
                    wr_strb  = WSTRB;
                end
                if (aw_held_d && w_held_d) begin
                    w_state_d = W_RESP;
                    mem_we    = in_range(wr_addr);
                    bvalid_d  = 1'b1;
                    bresp_d   = in_range(wr_addr) ? 2'b00 : 2'b10;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                end else begin
                    awready_d = !aw_held_d;
                    wready_d  = !w_held_d;
                end
            end
            W_RESP: begin
                if (bvalid_q && BREADY) begin
                    w_state_d = W_ACCEPT;
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: w_state_d = W_ACCEPT;
        endcase
    end

    // RDATA is captured on the edge after the AR handshake; mem is read before any same-edge write.
    always_comb begin
        r_state_d = r_state_q;
        araddr_d  = araddr_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_ACCEPT: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    araddr_d  = ARADDR;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (!rvalid_q) begin
                    rvalid_d = 1'b1;
                    rdata_d  = in_range(araddr_q) ? mem[word_idx(araddr_q)] : '0;
                    rresp_d  = in_range(araddr_q) ? 2'b00 : 2'b10;
                end else if (RREADY) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_ACCEPT;
                end
            end
            default: r_state_d = R_ACCEPT;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_ACCEPT;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            r_state_q <= R_ACCEPT;
            araddr_q  <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            r_state_q <= r_state_d;
            araddr_q  <= araddr_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESET && mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb[i]) mem[word_idx(wr_addr)][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
endmodule

// File: tb/tb_axi4l_slave_mem.sv
// tb/tb_axi4l_slave_mem.sv - scoreboard bench for axi4l_slave_mem
module tb_axi4l_slave_mem;
    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b1, ARVALID = 1'b0, RREADY = 1'b1;
    logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
    logic [3:0]  WSTRB = '0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [1:0]  BRESP, RRESP;
    logic [31:0] RDATA;

    axi4l_slave_mem dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    always #5 ACLK = ~ACLK;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [1:0]  bq [$];
    logic [33:0] rq [$];
    logic [1:0]  b_exp;
    logic [33:0] r_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Monitor: every completed B/R handshake is compared against the oldest expectation.
    always @(negedge ACLK) begin
        if (!ARESET && BVALID && BREADY) begin
            if (bq.size() == 0) fail_now("unexpected_b_response");
            else begin
                b_exp = bq.pop_front();
                chk("bresp", 32'(BRESP), 32'(b_exp));
            end
        end
        if (!ARESET && RVALID && RREADY) begin
            if (rq.size() == 0) fail_now("unexpected_r_response");
            else begin
                r_exp = rq.pop_front();
                chk("rdata", RDATA, r_exp[31:0]);
                chk("rresp", 32'(RRESP), 32'(r_exp[33:32]));
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, input logic [1:0] exp_resp, input bit push);
        bit aw_done = 0;
        bit w_done = 0;
        int k = 0;
        if (push) bq.push_back(exp_resp);
        AWADDR = addr; WDATA = data; WSTRB = strb;
        WVALID = 1'b1;
        AWVALID = (w_lead == 0);
        while (!(aw_done && w_done) && k < 50) begin
            @(negedge ACLK);
            if (AWVALID && AWREADY) aw_done = 1;
            if (WVALID && WREADY) w_done = 1;
            tick();
            k++;
            if (w_done) WVALID = 1'b0;
            if (aw_done) AWVALID = 1'b0;
            else if (k >= w_lead) AWVALID = 1'b1;
            if (w_lead > 0 && w_done && !aw_done) begin
                chk("wready_low_after_w", 32'(WREADY), 0);
                chk("awready_high_waiting_aw", 32'(AWREADY), 1);
            end
        end
        if (!(aw_done && w_done)) fail_now("write_handshake_timeout");
        else chk("bvalid_after_handshake", 32'(BVALID), 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
        bit done = 0;
        int k = 0;
        rq.push_back({exp_resp, exp_data});
        ARADDR = addr;
        ARVALID = 1'b1;
        while (!done && k < 50) begin
            @(negedge ACLK);
            if (ARREADY) done = 1;
            tick();
            k++;
        end
        ARVALID = 1'b0;
        if (!done) fail_now("read_handshake_timeout");
        else begin
            chk("rvalid_low_at_ar_edge", 32'(RVALID), 0);
            chk("arready_low_after_ar", 32'(ARREADY), 0);
            tick();
            chk("rvalid_latency", 32'(RVALID), 1);
        end
    endtask

    task automatic drain();
        int k = 0;
        while ((bq.size() != 0 || rq.size() != 0) && k < 100) begin
            tick();
            k++;
        end
        if (bq.size() != 0 || rq.size() != 0) begin
            fail_now("response_timeout");
            bq.delete();
            rq.delete();
        end
        tick();
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_awready"}, 32'(AWREADY), 0);
        chk({tag, "_wready"}, 32'(WREADY), 0);
        chk({tag, "_bvalid"}, 32'(BVALID), 0);
        chk({tag, "_bresp"}, 32'(BRESP), 0);
        chk({tag, "_arready"}, 32'(ARREADY), 0);
        chk({tag, "_rvalid"}, 32'(RVALID), 0);
        chk({tag, "_rdata"}, RDATA, 0);
        chk({tag, "_rresp"}, 32'(RRESP), 0);
    endtask

    task automatic chk_readies_up(input string tag);
        chk({tag, "_awready"}, 32'(AWREADY), 1);
        chk({tag, "_wready"}, 32'(WREADY), 1);
        chk({tag, "_arready"}, 32'(ARREADY), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) tick();
        chk_reset_outputs("reset");
        ARESET = 1'b0;
        tick();
        chk_readies_up("post_reset");

        // Same-cycle AW/W, then read back.
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 2'b00, 1);
        drain();
        do_read(32'h10, 32'hDEADBEEF, 2'b00);
        drain();

        // W leads AW by two cycles, strobes on bytes 0 and 2.
        do_write(32'h10, 32'h11223344, 4'h5, 2, 2'b00, 1);
        drain();
        do_read(32'h10, 32'hDE22BE44, 2'b00);
        drain();

        // Zero strobe writes nothing but responds OKAY.
        do_write(32'h10, 32'h0, 4'h0, 0, 2'b00, 1);
        drain();
        do_read(32'h10, 32'hDE22BE44, 2'b00);
        drain();

        // Out-of-range accesses.
        do_write(32'h0, 32'h01020304, 4'hF, 0, 2'b00, 1);
        do_write(32'hFFC, 32'h12345678, 4'hF, 0, 2'b00, 1);
        drain();
        do_read(32'h1000, 32'h0, 2'b10);
        drain();
        do_write(32'h1000, 32'hFFFFFFFF, 4'hF, 0, 2'b10, 1);
        drain();
        do_read(32'hFFC, 32'h12345678, 2'b00);
        drain();
        do_read(32'h0, 32'h01020304, 2'b00);
        drain();

        // Read response stall.
        RREADY = 1'b0;
        do_read(32'h10, 32'hDE22BE44, 2'b00);
        for (int i = 0; i < 5; i++) begin
            chk("rstall_rvalid", 32'(RVALID), 1);
            chk("rstall_rdata", RDATA, 32'hDE22BE44);
            chk("rstall_rresp", 32'(RRESP), 0);
            chk("rstall_arready", 32'(ARREADY), 0);
            tick();
        end
        RREADY = 1'b1;
        drain();

        // Write response stall.
        BREADY = 1'b0;
        do_write(32'h1004, 32'h5A5A5A5A, 4'hF, 0, 2'b10, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bstall_bvalid", 32'(BVALID), 1);
            chk("bstall_bresp", 32'(BRESP), 2);
            chk("bstall_awready", 32'(AWREADY), 0);
            chk("bstall_wready", 32'(WREADY), 0);
            tick();
        end
        BREADY = 1'b1;
        drain();

        // Collision: write commits on the same edge RDATA is captured.
        do_write(32'h20, 32'h0, 4'hF, 0, 2'b00, 1);
        drain();
        rq.push_back({2'b00, 32'h0});
        ARADDR = 32'h20;
        ARVALID = 1'b1;
        @(negedge ACLK);
        chk("coll_arready", 32'(ARREADY), 1);
        tick();
        ARVALID = 1'b0;
        bq.push_back(2'b00);
        AWADDR = 32'h20; WDATA = 32'hAAAA5555; WSTRB = 4'hF;
        AWVALID = 1'b1;
        WVALID = 1'b1;
        @(negedge ACLK);
        chk("coll_awready", 32'(AWREADY), 1);
        chk("coll_wready", 32'(WREADY), 1);
        tick();
        AWVALID = 1'b0;
        WVALID = 1'b0;
        chk("coll_bvalid", 32'(BVALID), 1);
        chk("coll_rvalid", 32'(RVALID), 1);
        drain();
        do_read(32'h20, 32'hAAAA5555, 2'b00);
        drain();

        // Reset while BVALID is pending and just after an AR handshake.
        BREADY = 1'b0;
        RREADY = 1'b0;
        do_write(32'h30, 32'h0BADF00D, 4'hF, 0, 2'b00, 0);
        ARADDR = 32'h30;
        ARVALID = 1'b1;
        @(negedge ACLK);
        chk("rst_arready", 32'(ARREADY), 1);
        tick();
        ARVALID = 1'b0;
        ARESET = 1'b1;
        tick();
        chk_reset_outputs("midrst");
        ARESET = 1'b0;
        BREADY = 1'b1;
        RREADY = 1'b1;
        tick();
        chk_readies_up("midrst_release");
        chk("midrst_bvalid_dropped", 32'(BVALID), 0);
        chk("midrst_rvalid_dropped", 32'(RVALID), 0);
        repeat (3) tick();
        chk("midrst_no_late_rvalid", 32'(RVALID), 0);
        do_read(32'h30, 32'h0BADF00D, 2'b00);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
